// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache between IF and instruction_memory.
// Hits return combinationally; misses stall IF and fetch one 128-bit block.
module instruction_cache #(
  parameter int LINES     = 8,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 read,
  input  logic [31:0]          address,
  input  logic                 flush,
  output logic [31:0]          instruction,
  output logic                 busywait,
  output logic                 mem_read,
  output logic [27:0]          mem_address,
  input  logic [127:0]         mem_readinst,
  input  logic                 mem_busywait,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 28 - IDX_W;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 first_q, first_d;
  logic [LINES-1:0]     valid_q, valid_d;
  logic [27:0]          mem_address_q, mem_address_d;
  logic [CNT_WIDTH-1:0] hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0] miss_cnt_q, miss_cnt_d;

  logic [TAG_W-1:0]     tag_q  [LINES];
  logic [127:0]         data_q [LINES];

  logic [IDX_W-1:0]     idx;
  logic [TAG_W-1:0]     tag;
  logic [1:0]           offset;
  logic [127:0]         line;
  logic                 hit;
  logic                 fill_we;
  logic [IDX_W-1:0]     fill_idx;
  logic [TAG_W-1:0]     fill_tag;
  logic                 unused_addr_bits;

  assign idx              = address[4 +: IDX_W];
  assign tag              = address[31 -: TAG_W];
  assign offset           = address[3:2];
  assign unused_addr_bits = ^address[1:0];
  assign line             = data_q[idx];
  assign hit              = read & valid_q[idx] & (tag_q[idx] == tag);

  // The latched block address also carries the index and tag of the line being filled.
  assign fill_idx = mem_address_q[IDX_W-1:0];
  assign fill_tag = mem_address_q[27 -: TAG_W];

  assign mem_address = mem_address_q;
  assign hit_count   = hit_cnt_q;
  assign miss_count  = miss_cnt_q;

  always_comb begin
    state_d       = state_q;
    first_d       = 1'b0;
    valid_d       = valid_q;
    mem_address_d = mem_address_q;
    hit_cnt_d     = hit_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    instruction   = 32'd0;
    busywait      = 1'b0;
    mem_read      = 1'b0;
    fill_we       = 1'b0;

    case (state_q)
      IDLE: begin
        // Outputs stay quiet while reset is held, even with a request pending.
        if (read && reset) begin
          if (hit) begin
            instruction = line[{offset, 5'b00000} +: 32];
            if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_ONE;
          end else begin
            busywait      = 1'b1;
            state_d       = MEM_READ;
            first_d       = 1'b1;
            mem_address_d = address[31:4];
            if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_ONE;
          end
        end
      end
      MEM_READ: begin
        mem_read = 1'b1;
        busywait = 1'b1;
        if (!first_q && !mem_busywait) state_d = UPDATE;
      end
      UPDATE: begin
        busywait          = 1'b1;
        fill_we           = 1'b1;
        valid_d[fill_idx] = 1'b1;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Flush wins over the fill's valid set, leaving the line invalid.
    if (flush) valid_d = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      first_q       <= 1'b0;
      valid_q       <= '0;
      mem_address_q <= '0;
      hit_cnt_q     <= '0;
      miss_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      first_q       <= first_d;
      valid_q       <= valid_d;
      mem_address_q <= mem_address_d;
      hit_cnt_q     <= hit_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
    end
  end

  always_ff @(posedge clock) begin
    if (fill_we) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mem_readinst;
    end
  end

endmodule
